// File: rtl/signed_mult32_seq.sv
// ---------------------------------------------------------------------------
// signed_mult32_seq
//   Sequential 32x32 multiplier built around a single combinational 16x16
//   vedic core that is reused over four cycles. Operands are converted to
//   magnitudes on accept, the four partial products are accumulated into a
//   64-bit accumulator, and the sign is applied in a final fix-up cycle.
//
//   Parameter
//     SIGNED_MODE   1: two's complement operands/product, 0: unsigned
//
//   Optional build macro
//     MULT_ZERO_SKIP_EN  when defined, an accepted pair with a zero operand
//                        bypasses MUL/FIX and presents product 0 one cycle
//                        after acceptance. Undefined: every pair takes the
//                        full 6-cycle path and no zero detection exists.
//
//   Ports
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   operand pair valid
//     in_ready   out  block accepts an operand pair (registered)
//     a, b       in   32-bit multiplicand / multiplier
//     out_valid  out  product valid (registered)
//     out_ready  in   consumer takes the product
//     product    out  64-bit result (registered)
//     busy       out  high whenever the FSM is not idle
//
//   Helper modules in this file: vedic_mult_2bit/4bit/8bit/16bit (unsigned
//   vedic multipliers, each built from four of the next smaller size).
// ---------------------------------------------------------------------------

// 2x2 vedic cell: purely gate level
module vedic_mult_2bit (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);
  logic w_c;

  assign o_p[0] = i_a[0] & i_b[0];
  assign o_p[1] = (i_a[1] & i_b[0]) ^ (i_a[0] & i_b[1]);
  assign w_c    = (i_a[1] & i_b[0]) & (i_a[0] & i_b[1]);
  assign o_p[2] = (i_a[1] & i_b[1]) ^ w_c;
  assign o_p[3] = (i_a[1] & i_b[1]) & w_c;
endmodule

// 4x4 from four 2x2 cells: {hh,ll} + (hl + lh) << 2
module vedic_mult_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [3:0] w_ll, w_hl, w_lh, w_hh;

  vedic_mult_2bit u_ll (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_p(w_ll));
  vedic_mult_2bit u_hl (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_p(w_hl));
  vedic_mult_2bit u_lh (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_p(w_lh));
  vedic_mult_2bit u_hh (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_p(w_hh));

  assign o_p = {w_hh, w_ll} + {2'b00, w_hl, 2'b00} + {2'b00, w_lh, 2'b00};
endmodule

module vedic_mult_8bit (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  logic [7:0] w_ll, w_hl, w_lh, w_hh;

  vedic_mult_4bit u_ll (.i_a(i_a[3:0]), .i_b(i_b[3:0]), .o_p(w_ll));
  vedic_mult_4bit u_hl (.i_a(i_a[7:4]), .i_b(i_b[3:0]), .o_p(w_hl));
  vedic_mult_4bit u_lh (.i_a(i_a[3:0]), .i_b(i_b[7:4]), .o_p(w_lh));
  vedic_mult_4bit u_hh (.i_a(i_a[7:4]), .i_b(i_b[7:4]), .o_p(w_hh));

  assign o_p = {w_hh, w_ll} + {4'h0, w_hl, 4'h0} + {4'h0, w_lh, 4'h0};
endmodule

module vedic_mult_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  logic [15:0] w_ll, w_hl, w_lh, w_hh;

  vedic_mult_8bit u_ll (.i_a(i_a[7:0]),  .i_b(i_b[7:0]),  .o_p(w_ll));
  vedic_mult_8bit u_hl (.i_a(i_a[15:8]), .i_b(i_b[7:0]),  .o_p(w_hl));
  vedic_mult_8bit u_lh (.i_a(i_a[7:0]),  .i_b(i_b[15:8]), .o_p(w_lh));
  vedic_mult_8bit u_hh (.i_a(i_a[15:8]), .i_b(i_b[15:8]), .o_p(w_hh));

  // The true product fits in 32 bits, so the sum cannot carry out.
  assign o_p = {w_hh, w_ll} + {8'h00, w_hl, 8'h00} + {8'h00, w_lh, 8'h00};
endmodule

// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// MUL   | four core passes, one partial product per cycle
// FIX   | apply sign to accumulator, load product
// DONE  | product presented, waiting for out_ready
// ---------------------------------------------------------------------------
module signed_mult32_seq #(
  parameter int SIGNED_MODE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic        r_sign;
  logic [63:0] r_acc;
  logic [1:0]  r_step;

  logic        w_accept;
  logic        w_zero_op;
  logic        w_out_hs;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_sign;
  logic [15:0] w_core_a;
  logic [15:0] w_core_b;
  logic [31:0] w_core_p;
  logic [63:0] w_partial;

  assign w_accept = (r_state == IDLE) && in_valid && in_ready;
  assign w_out_hs = (r_state == DONE) && out_valid && out_ready;
  assign busy     = (r_state != IDLE);

`ifdef MULT_ZERO_SKIP_EN
  assign w_zero_op = (a == 32'd0) || (b == 32'd0);
`else
  assign w_zero_op = 1'b0;
`endif

  // Magnitudes: plain 32-bit negation, so -2^31 maps onto 0x8000_0000,
  // which is still the correct unsigned magnitude.
  assign w_mag_a = ((SIGNED_MODE != 0) && a[31]) ? (~a + 32'd1) : a;
  assign w_mag_b = ((SIGNED_MODE != 0) && b[31]) ? (~b + 32'd1) : b;
  assign w_sign  = (SIGNED_MODE != 0) ? (a[31] ^ b[31]) : 1'b0;

  // Step order: aL*bL, aL*bH, aH*bL, aH*bH
  assign w_core_a = r_step[1] ? r_mag_a[31:16] : r_mag_a[15:0];
  assign w_core_b = r_step[0] ? r_mag_b[31:16] : r_mag_b[15:0];

  vedic_mult_16bit u_core (
    .i_a (w_core_a),
    .i_b (w_core_b),
    .o_p (w_core_p)
  );

  always_comb begin
    w_partial = 64'd0;
    case (r_step)
      2'd0:    w_partial = {32'd0, w_core_p};
      2'd1,
      2'd2:    w_partial = {16'd0, w_core_p, 16'd0};
      default: w_partial = {w_core_p, 32'd0};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero_op ? DONE : MUL;
        end
      end
      MUL: begin
        if (r_step == 2'd3) begin
          w_state_nxt = FIX;
        end
      end
      FIX:  w_state_nxt = DONE;
      DONE: begin
        if (w_out_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      product   <= 64'd0;
      r_acc     <= 64'd0;
      r_step    <= 2'd0;
      r_mag_a   <= 32'd0;
      r_mag_b   <= 32'd0;
      r_sign    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            in_ready <= 1'b0;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_sign   <= w_sign;
            r_acc    <= 64'd0;
            r_step   <= 2'd0;
            if (w_zero_op) begin
              product   <= 64'd0;
              out_valid <= 1'b1;
            end
          end else begin
            // First edge out of reset raises in_ready here.
            in_ready <= 1'b1;
          end
        end
        MUL: begin
          r_acc  <= r_acc + w_partial;
          r_step <= r_step + 2'd1;
        end
        FIX: begin
          product   <= r_sign ? (~r_acc + 64'd1) : r_acc;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (w_out_hs) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_mult32_seq.sv
module tb_signed_mult32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;

  logic        in_ready_s, out_valid_s, busy_s;
  logic [63:0] product_s;
  logic        in_ready_u, out_valid_u, busy_u;
  logic [63:0] product_u;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_s, exp_u;

  always #5 clk = ~clk;

  signed_mult32_seq #(.SIGNED_MODE(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .product(product_s), .busy(busy_s)
  );

  signed_mult32_seq #(.SIGNED_MODE(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .a(a), .b(b), .out_valid(out_valid_u), .out_ready(out_ready),
    .product(product_u), .busy(busy_u)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the interpreted operand values.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input bit sgn);
    longint sx, sy;
    longint unsigned ux, uy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = 64'(x);
    uy = 64'(y);
    return ux * uy;
  endfunction

  function automatic int model_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef MULT_ZERO_SKIP_EN
    if (x == 32'd0 || y == 32'd0) return 1;
`endif
    return 6;
  endfunction

  // Starts at a negedge; returns 1ns after the accepting posedge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    check("in_ready_s before accept", {63'd0, in_ready_s}, 64'd1);
    check("in_ready_u before accept", {63'd0, in_ready_u}, 64'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Counts cycles after acceptance until out_valid; ends at that negedge.
  task automatic wait_result(input logic [31:0] x, input logic [31:0] y, input string tag);
    int k = 0;
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    exp_s = model(x, y, 1'b1);
    exp_u = model(x, y, 1'b0);
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (!(busy_s && busy_u)) busy_ok = 1'b0;
      if (out_valid_s) seen = 1'b1;
    end
    check({tag, " latency"}, 64'(k), 64'(model_lat(x, y)));
    check({tag, " busy while pending"}, {63'd0, busy_ok}, 64'd1);
    check({tag, " out_valid_u"}, {63'd0, out_valid_u}, 64'd1);
    check({tag, " product signed"}, product_s, exp_s);
    check({tag, " product unsigned"}, product_u, exp_u);
  endtask

  task automatic release_result(input int hold, input string tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " held product"}, product_s, exp_s);
      check({tag, " held out_valid"}, {63'd0, out_valid_s}, 64'd1);
      check({tag, " held in_ready"}, {63'd0, in_ready_s}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " out_valid cleared"}, {63'd0, out_valid_s}, 64'd0);
    check({tag, " in_ready set"}, {63'd0, in_ready_s}, 64'd1);
    check({tag, " busy cleared"}, {63'd0, busy_u}, 64'd0);
    check({tag, " product retained s"}, product_s, exp_s);
    check({tag, " product retained u"}, product_u, exp_u);
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int hold, input string tag);
    issue(x, y);
    wait_result(x, y, tag);
    release_result(hold, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_ov;
    #2;
    check("reset in_ready", {63'd0, in_ready_s}, 64'd0);
    check("reset out_valid", {63'd0, out_valid_s}, 64'd0);
    check("reset busy", {63'd0, busy_s}, 64'd0);
    check("reset product", product_s, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset s", {63'd0, in_ready_s}, 64'd1);
    check("in_ready after reset u", {63'd0, in_ready_u}, 64'd1);

    do_op(32'd3, 32'hFFFF_FFFB, 0, "3x-5");
    check("3x-5 literal", product_s, 64'hFFFF_FFFF_FFFF_FFF1);

    do_op(32'h8000_0000, 32'h8000_0000, 1, "minxmin");
    check("minxmin literal", product_s, 64'h4000_0000_0000_0000);

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "allones");
    check("allones literal s", product_s, 64'h0000_0000_0000_0001);
    check("allones literal u", product_u, 64'hFFFF_FFFE_0000_0001);

    do_op(32'd0, 32'd123, 0, "zero_a");
    check("zero_a literal", product_s, 64'd0);

    // Backpressure with a new pair waiting on the input.
    issue(32'd11, 32'd13);
    wait_result(32'd11, 32'd13, "bp first");
    in_valid = 1'b1;
    a = 32'd9;
    b = 32'd2;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("bp held out_valid", {63'd0, out_valid_s}, 64'd1);
      check("bp held in_ready", {63'd0, in_ready_s}, 64'd0);
      check("bp held product", product_s, exp_s);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp out_valid cleared", {63'd0, out_valid_s}, 64'd0);
    check("bp in_ready set", {63'd0, in_ready_s}, 64'd1);
    check("bp a=9 not yet taken", {63'd0, busy_s}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(32'd9, 32'd2, "bp second");
    check("bp second literal", product_s, 64'd18);
    release_result(0, "bp second");

    // Reset in the middle of an operation.
    issue(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", {63'd0, out_valid_s}, 64'd0);
    check("midreset in_ready", {63'd0, in_ready_s}, 64'd0);
    check("midreset busy", {63'd0, busy_s}, 64'd0);
    check("midreset product s", product_s, 64'd0);
    check("midreset product u", product_u, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_ov = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_s || out_valid_u) seen_ov = 1'b1;
    end
    check("midreset no stale out_valid", {63'd0, seen_ov}, 64'd0);
    do_op(32'd7, 32'd6, 0, "7x6");
    check("7x6 literal", product_s, 64'd42);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      int sel;
      x = $urandom;
      y = $urandom;
      sel = $urandom_range(0, 6);
      if (sel == 0) x = 32'd0;
      if (sel == 1) y = 32'd0;
      if (sel == 2) x = 32'h8000_0000;
      if (sel == 3) y = 32'hFFFF_FFFF;
      do_op(x, y, $urandom_range(0, 2), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/signed_mult32_seq.md
SIGNED_MULT32_SEQ -- requirements
Module: signed_mult32_seq

Interface
REQ-001 SHALL have parameter SIGNED_MODE, default 1; 1 = operands and product are two's complement, 0 = operands and product are unsigned.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b is valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair; registered.
REQ-006 SHALL have port a  input  32  multiplicand.
REQ-007 SHALL have port b  input  32  multiplier.
REQ-008 SHALL have port out_valid  output  1  product is valid; registered.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the product this cycle.
REQ-010 SHALL have port product  output  64  a*b result; registered.
REQ-011 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-012 SHALL instantiate exactly one combinational vedic_mult_16bit core (16x16 unsigned to 32-bit) and reuse it over 4 cycles.
REQ-013 SHALL implement the FSM states IDLE, MUL, FIX and DONE.
REQ-014 SHALL accept operands when in_valid && in_ready (cycle T); SHALL then latch |a|, |b| and sign = a[31]^b[31] (sign forced to 0 when SIGNED_MODE=0), clear the 64-bit accumulator and go IDLE->MUL.
REQ-015 SHALL take magnitudes in SIGNED_MODE=1 as 32-bit unsigned two's-complement negation of negative operands, so -2^31 maps to 0x8000_0000.
REQ-016 SHALL use a 2-bit step counter in MUL; steps 0..3 SHALL feed the core aL*bL, aL*bH, aH*bL, aH*bH and add the core output shifted left by 0, 16, 16 and 32 bits into the accumulator, over cycles T+1..T+4.
REQ-017 SHALL go MUL->FIX after step 3; FIX (cycle T+5) SHALL write product = sign ? -acc : acc (64-bit two's complement) and move to DONE.
REQ-018 SHALL assert out_valid from cycle T+6 (latency 6 cycles), holding product and out_valid stable until out_ready is sampled high.
REQ-019 SHALL, on out_valid && out_ready: clear out_valid, go DONE->IDLE, and set in_ready in the same edge; product SHALL retain its last value.
REQ-020 SHALL drive in_ready low in every state other than IDLE; in_valid SHALL be ignored outside IDLE (no overlap, no queuing).
REQ-021 SHALL never let the accumulator overflow 64 bits; a zero product SHALL stay 0 after negation.
REQ-022 SHALL keep in_ready at 0 while out_valid is held under backpressure.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously force: state IDLE, in_ready 0, out_valid 0, busy 0, product 0, accumulator 0, step 0.
REQ-024 SHALL set in_ready to 1 on the first clk edge after rst_n deasserts.
REQ-025 SHALL, on reset during MUL, FIX or DONE, abort the operation and discard its result; no out_valid SHALL follow for that operation.

Configuration
REQ-026 SHALL provide macro MULT_ZERO_SKIP_EN; when defined, an accepted pair with a==0 or b==0 SHALL skip MUL/FIX, load product 0 and assert out_valid at T+1.
REQ-027 SHALL, when MULT_ZERO_SKIP_EN is undefined, apply the 6-cycle path to all operands, with no zero-detect logic present.

Verification
REQ-028 SHALL test SIGNED_MODE=1, a=3, b=0xFFFF_FFFB (-5) -> product 0xFFFF_FFFF_FFFF_FFF1 with out_valid at T+6 and busy high T+1..T+6.
REQ-029 SHALL test SIGNED_MODE=1, a=b=0x8000_0000 -> product 0x4000_0000_0000_0000.
REQ-030 SHALL test a=b=0xFFFF_FFFF -> product 0x0000_0000_0000_0001 for SIGNED_MODE=1, and 0xFFFF_FFFE_0000_0001 for SIGNED_MODE=0.
REQ-031 SHALL test out_ready held low 3 cycles after out_valid, with in_valid high carrying a=9 -> product stable, in_ready 0, and a=9 not accepted until the cycle after out_ready.
REQ-032 SHALL test rst_n pulsed low at T+3 -> all outputs zero immediately and no out_valid; then a=7, b=6 -> product 42 at T'+6.
REQ-033 SHALL test a=0, b=123 -> product 0 with out_valid at T+1 when MULT_ZERO_SKIP_EN is defined, and at T+6 when it is undefined.
